// File: rtl/sietesegmentos_pkg.sv
// Shared constants for the seven-segment scanner: segment table, blank pattern, anode helper.
// Segment vectors are [0:6] = a..g, active-low.
package sietesegmentos_pkg;

    typedef logic [0:6] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;

    localparam seg_t SEG_TABLE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Active-low anode vector for up to 8 digits; caller truncates to its digit count.
    function automatic logic [7:0] one_cold(input logic [2:0] idx);
        return ~(8'b0000_0001 << idx);
    endfunction

endpackage

// File: rtl/sietesegmentos_mux_if.sv
// Load/data inputs and display outputs of the scanner, grouped as one bundle.
// master drives the data side, slave is the display driver.
interface sietesegmentos_mux_if #(
    parameter int N_DIGITS = 4
);
    logic                    load;
    logic [4*N_DIGITS-1:0]   value;
    logic [N_DIGITS-1:0]     dp_in;
    logic                    lz_suppress;
    logic [0:6]              SSeg;
    logic                    dp;
    logic [N_DIGITS-1:0]     an;
    logic                    frame_tick;

    modport master (
        output load, value, dp_in, lz_suppress,
        input  SSeg, dp, an, frame_tick
    );

    modport slave (
        input  load, value, dp_in, lz_suppress,
        output SSeg, dp, an, frame_tick
    );
endinterface

// File: rtl/sietesegmentos_mux_hex7seg.sv
// Combinational hex nibble to active-low segment decoder.
// Zero latency; no flow control.
module hex7seg
    import sietesegmentos_pkg::*;
(
    input  logic [3:0] nib_i,
    output seg_t       seg_o
);
    assign seg_o = SEG_TABLE[nib_i];
endmodule

// File: rtl/sietesegmentos_mux.sv
// Time-multiplexed seven-segment driver with shadow registers and leading-zero blanking.
// All outputs registered (one cycle after the state they reflect); free-running, no backpressure.
module sietesegmentos_mux
    import sietesegmentos_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int DIV      = 50000
) (
    input  logic           clk,
    input  logic           rst,
    sietesegmentos_mux_if.slave bus
);
    localparam int CW = $clog2(DIV);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*N_DIGITS-1:0] val_q;
    logic [N_DIGITS-1:0]   dps_q;
    logic                  wrapped_q;
    seg_t                  seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic                  ft_q;

    logic                  cnt_wrap;
    logic                  frame_end;
    logic                  guard;
    logic                  upper_nz;
    logic                  blank;
    logic [3:0]            nib;
    seg_t                  dec_seg;

    assign cnt_wrap  = (cnt_q == CW'(DIV - 1));
    assign frame_end = cnt_wrap && (idx_q == IW'(N_DIGITS - 1));
    assign guard     = (cnt_q == '0);
    assign nib       = val_q[{idx_q, 2'b00} +: 4];

    hex7seg u_dec (
        .nib_i (nib),
        .seg_o (dec_seg)
    );

    // A digit is blanked when it and every more significant nibble are zero.
    always_comb begin
        upper_nz = 1'b0;
        for (int j = 0; j < N_DIGITS; j++) begin
            if (j >= int'(idx_q) && val_q[4*j +: 4] != 4'h0) begin
                upper_nz = 1'b1;
            end
        end
        blank = bus.lz_suppress && (idx_q != '0) && !upper_nz;
    end

    always_comb begin
        cnt_d = cnt_wrap ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_wrap) begin
            idx_d = (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        an_d  = guard ? '1 : N_DIGITS'(one_cold(3'(idx_q)));
        seg_d = (guard || blank) ? SEG_BLANK : dec_seg;
        dp_d  = guard ? 1'b1 : ~dps_q[idx_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            val_q     <= '0;
            dps_q     <= '0;
            wrapped_q <= 1'b0;
            seg_q     <= SEG_BLANK;
            dp_q      <= 1'b1;
            an_q      <= '1;
            ft_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            wrapped_q <= frame_end;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            an_q      <= an_d;
            // The tick lands with the first guard gap of the next frame.
            ft_q      <= wrapped_q;
            if (bus.load) begin
                val_q <= bus.value;
                dps_q <= bus.dp_in;
            end
        end
    end

    assign bus.SSeg       = seg_q;
    assign bus.dp         = dp_q;
    assign bus.an         = an_q;
    assign bus.frame_tick = ft_q;

endmodule

// File: tb/tb_sietesegmentos_mux.sv
module tb_sietesegmentos_mux;
    localparam int ND    = 4;
    localparam int DV    = 4;
    localparam int FRAME = ND * DV;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sietesegmentos_mux_if #(.N_DIGITS(ND)) bus();

    sietesegmentos_mux #(.N_DIGITS(ND), .DIV(DV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [0:6] seg_ref [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
    logic [3:0] an_seq [16] = '{
        4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
        4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7
    };

    // Reference model: position in the scan since reset plus the captured data.
    bit         mdl_valid = 1'b0;
    int         mdl_pos   = 0;
    logic [15:0] sh_val   = '0;
    logic [3:0]  sh_dp    = '0;
    logic [3:0]  e_an;
    logic [0:6]  e_seg;
    logic        e_dp;
    logic        e_ft;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            int c;
            int d;
            logic [3:0] nib;
            @(posedge clk);
            if (rst) begin
                e_an = '1; e_seg = 7'b1111111; e_dp = 1'b1; e_ft = 1'b0;
                mdl_pos = 0; sh_val = '0; sh_dp = '0; mdl_valid = 1'b1;
            end else if (mdl_valid) begin
                c = mdl_pos % DV;
                d = (mdl_pos / DV) % ND;
                if (c == 0) begin
                    e_an = '1; e_seg = 7'b1111111; e_dp = 1'b1;
                end else begin
                    e_an = ~(4'b0001 << d);
                    nib  = 4'(sh_val >> (4 * d));
                    if (bus.lz_suppress && d > 0 && (sh_val >> (4 * d)) == 16'h0)
                        e_seg = 7'b1111111;
                    else
                        e_seg = seg_ref[nib];
                    e_dp = ~sh_dp[d];
                end
                e_ft = (mdl_pos > 0) && (mdl_pos % FRAME == 0);
                mdl_pos++;
                if (bus.load) begin
                    sh_val = bus.value;
                    sh_dp  = bus.dp_in;
                end
            end
            @(negedge clk);
            if (mdl_valid) begin
                check("model_an",   32'(bus.an),         32'(e_an));
                check("model_seg",  32'(bus.SSeg),       32'(e_seg));
                check("model_dp",   32'(bus.dp),         32'(e_dp));
                check("model_tick", 32'(bus.frame_tick), 32'(e_ft));
            end
        end
    end

    task automatic wait_digit(input int k, input logic [0:6] s, input logic d, input string name);
        bit found;
        logic [3:0] want;
        found = 1'b0;
        want  = ~(4'b0001 << k);
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (bus.an == want) begin
                found = 1'b1;
                check({name, "_seg"}, 32'(bus.SSeg), 32'(s));
                check({name, "_dp"},  32'(bus.dp),   32'(d));
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL %s: digit %0d never selected, an=%b", name, k, bus.an);
        end
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] p);
        @(negedge clk);
        bus.load = 1'b1; bus.value = v; bus.dp_in = p;
        @(negedge clk);
        bus.load = 1'b0; bus.value = 16'h9999; bus.dp_in = 4'hF;
    endtask

    initial begin
        int ticks;
        bit hit;
        bus.load = 1'b0; bus.value = '0; bus.dp_in = '0; bus.lz_suppress = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_an",   32'(bus.an),         32'hF);
        check("rst_seg",  32'(bus.SSeg),       32'h7F);
        check("rst_dp",   32'(bus.dp),         32'h1);
        check("rst_tick", 32'(bus.frame_tick), 32'h0);
        rst = 1'b0;

        ticks = 0;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            if (i < 16) check("scan_an", 32'(bus.an), 32'(an_seq[i]));
            if (bus.an != 4'hF) check("scan_zero", 32'(bus.SSeg), 32'(7'b0000001));
            if (bus.frame_tick) ticks++;
        end
        check("tick_count", ticks, 2);

        pulse_load(16'h12EF, 4'b0100);
        wait_digit(0, 7'b0111000, 1'b1, "h12EF_d0");
        wait_digit(1, 7'b0110000, 1'b1, "h12EF_d1");
        wait_digit(2, 7'b0010010, 1'b0, "h12EF_d2");
        wait_digit(3, 7'b1001111, 1'b1, "h12EF_d3");

        bus.lz_suppress = 1'b1;
        pulse_load(16'h0050, 4'b0000);
        wait_digit(3, 7'b1111111, 1'b1, "lz50_d3");
        wait_digit(2, 7'b1111111, 1'b1, "lz50_d2");
        wait_digit(1, 7'b0100100, 1'b1, "lz50_d1");
        wait_digit(0, 7'b0000001, 1'b1, "lz50_d0");
        pulse_load(16'h0000, 4'b0000);
        wait_digit(1, 7'b1111111, 1'b1, "lz0_d1");
        wait_digit(0, 7'b0000001, 1'b1, "lz0_d0");

        bus.lz_suppress = 1'b0;
        bus.value = 16'hAAAA; bus.dp_in = 4'hF;
        wait_digit(3, 7'b0000001, 1'b1, "noload_d3");
        pulse_load(16'hAAAA, 4'hF);
        wait_digit(0, 7'b0001000, 1'b0, "hAAAA_d0");
        wait_digit(3, 7'b0001000, 1'b0, "hAAAA_d3");

        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (mdl_pos % FRAME == 2 * DV + 2) hit = 1'b1;
        end
        if (!hit) begin
            checks++; errors++;
            $display("FAIL midrst_align: idx=2 cnt=2 never reached");
        end
        rst = 1'b1;
        @(negedge clk);
        check("midrst_an",  32'(bus.an),   32'hF);
        check("midrst_seg", 32'(bus.SSeg), 32'h7F);
        rst = 1'b0;
        @(negedge clk);
        check("restart_guard", 32'(bus.an), 32'hF);
        @(negedge clk);
        check("restart_d0",  32'(bus.an),   32'hE);
        check("cleared_seg", 32'(bus.SSeg), 32'(7'b0000001));
        wait_digit(3, 7'b0000001, 1'b1, "cleared_d3");

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst             = ($urandom_range(0, 199) == 0);
            bus.load        = ($urandom_range(0, 7) == 0);
            bus.value       = 16'($urandom);
            bus.dp_in       = 4'($urandom);
            bus.lz_suppress = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) bus.value = bus.value & 16'h00FF;
        end
        @(negedge clk);
        rst = 1'b0; bus.load = 1'b0;
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sietesegmentos_mux.md
SIETESEGMENTOS_MUX -- requirements
Module: sietesegmentos_mux

Interface
REQ-001 Parameter N_DIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-002 Parameter DIV, default 50000, clocks per digit slot; legal value >= 2.
REQ-003 Port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  reset; synchronous and active-high.
REQ-005 Port load  input  1  single-cycle strobe; captures value and dp_in into the shadow registers.
REQ-006 Port value  input  4*N_DIGITS  hex nibbles; nibble k (bits 4k+3:4k) drives digit k; digit 0 is least significant.
REQ-007 Port dp_in  input  N_DIGITS  decimal point request per digit; 1 = lit.
REQ-008 Port lz_suppress  input  1  leading-zero blanking enable; sampled live, not captured by load.
REQ-009 Port SSeg  output  7, indexed [0:6]  segments a..g; SSeg[0] = a; active-low.
REQ-010 Port dp  output  1  decimal point; active-low.
REQ-011 Port an  output  N_DIGITS  digit anodes; active-low, one-cold.
REQ-012 Port frame_tick  output  1  one-cycle pulse per completed refresh frame.

Function
REQ-013 Refresh counter cnt counts 0..DIV-1 and wraps to 0; digit index idx advances by 1 when cnt wraps, and wraps from N_DIGITS-1 to 0.
REQ-014 All outputs are registered: each cycle's outputs are computed from the previous cycle's cnt, idx, shadow registers and lz_suppress.
REQ-015 Guard gap: when cnt==0, an is all ones, SSeg is 1111111 and dp is 1, so no two digits are ever lit in the same cycle.
REQ-016 When cnt!=0, an[idx]=0 and all other an bits are 1.
REQ-017 Decode of the shadow nibble (SSeg[0..6]), lit segment = 0:
  0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111,
  8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-018 dp = ~dp_shadow[idx] outside the guard gap.
REQ-019 load=1 captures value and dp_in into the shadow registers at that edge; the new data is visible on outputs from the next edge (1-cycle latency from capture to output).
REQ-020 Absent a load, the shadow registers hold indefinitely; changes on value or dp_in without load never reach the outputs.
REQ-021 Leading-zero suppression, when lz_suppress=1:
  - Digit k is blanked (SSeg=1111111) if shadow nibbles N_DIGITS-1 down to k are all zero.
  - Digit 0 is never blanked.
  - an still selects a blanked digit; dp still follows REQ-018.
REQ-022 frame_tick=1 for exactly one cycle, on the edge after cnt wraps while idx==N_DIGITS-1.
REQ-023 load coincident with a slot or frame change: the capture still occurs, and the refresh sequence is undisturbed.
REQ-024 load held high for several cycles re-captures every cycle; the last captured value is displayed.

Reset
REQ-025 While rst=1 at a rising edge, the following clear: cnt=0, idx=0, shadow value=0, shadow dp=0.
REQ-026 While rst=1 at a rising edge, outputs are forced to an=all ones, SSeg=1111111, dp=1, frame_tick=0.
REQ-027 Reset asserted mid-slot or mid-frame aborts the sequence; after release, scanning restarts at digit 0 with a guard-gap cycle.
REQ-028 A load in a cycle where rst=1 is ignored.

Structure
REQ-029 A shared package sietesegmentos_pkg holds:
  - the 16-entry segment constant table;
  - the SEG_BLANK constant (1111111);
  - the helper that builds the one-cold anode vector.
REQ-030 Decoder sub-module hex7seg: combinational nibble to SSeg[0:6] per REQ-017, instantiated once on the muxed nibble.
REQ-031 cnt width is $clog2(DIV); idx width is max(1,$clog2(N_DIGITS)).

Verification (bench: N_DIGITS=4, DIV=4)
REQ-032 Reset, then no load -> repeating sequence:
  - an = 1111, 1110 x3, 1111, 1101 x3, 1111, 1011 x3, 1111, 0111 x3;
  - SSeg=0000001 on every lit cycle;
  - frame_tick one pulse every 16 cycles.
REQ-033 load with value=16'h12EF, dp_in=4'b0100:
  - digit0 = 0111000, digit1 = 0110000, digit2 = 0010010 with dp=0, digit3 = 1001111;
  - the first changed output appears 1 cycle after the load edge.
REQ-034 value=16'h0050, lz_suppress=1:
  - digits 3 and 2 show 1111111, digit1 = 0100100, digit0 = 0000001;
  - with value=16'h0000, only digit0 is lit (0000001).
REQ-035 value changed to 16'hAAAA without load -> display unchanged; then pulse load -> all digits show 0001000.
REQ-036 rst pulsed mid-frame (idx=2, cnt=2):
  - next edge shows an=1111, SSeg=1111111;
  - shadow value reads back as 0;
  - scan restarts at digit 0.
